// File: rtl/mem_responder.sv
// Single-word memory responder: req/ready handshake, programmable wait states,
// misalignment and range checking in front of a word-organised RAM.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ram [DEPTH];

  logic                  eff_we;
  logic [31:0]           eff_addr;
  logic [31:0]           eff_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  bad;
  logic                  respond;
  logic                  commit;

  // With zero wait states the response is formed on the acceptance edge,
  // so the live request inputs are used instead of the latched copy.
  always_comb begin
    eff_we    = (state_q == S_IDLE) ? mem_we    : we_q;
    eff_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
    eff_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
    idx       = eff_addr[DEPTH_LOG2+1:2];
    bad       = (eff_addr[1:0] != 2'b00) || (eff_addr[31:DEPTH_LOG2+2] != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    respond = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          if (WAIT_CYCLES == 0) begin
            respond = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) respond = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (respond) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      err_d   = bad;
      rdata_d = (bad || eff_we) ? '0 : ram[idx];
    end
    commit = respond && eff_we && !bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; reset only blocks a write that would commit on this edge.
  always_ff @(posedge clk) begin
    if (!reset && commit) ram[idx] <= eff_wdata;
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: dut0 uses two wait states, dut1 none.
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst [2];
  logic        req [2];
  logic        we  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];
  logic [1:0]  st    [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last1    = -1;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .mem_req(req[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_ready(ready[0]),
    .mem_rdata(rdata[0]), .mem_err(err[0]), .busy(busy[0]), .state(st[0])
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_req(req[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_ready(ready[1]),
    .mem_rdata(rdata[1]), .mem_err(err[1]), .busy(busy[1]), .state(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ready[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe dut%0d actual rdata=0x%08h err=%b required no strobe",
                   k, rdata[k], err[k]);
        end else begin
          if (k == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("rdata_dut%0d", k), rdata[k], mon_e.rdata);
          chk($sformatf("err_dut%0d", k), {31'd0, err[k]}, {31'd0, mon_e.err});
        end
        if (k == 1) begin
          if (last1 >= 0) chk("ready_spacing_dut1", cyc - last1, 32'd2);
          last1 = cyc;
        end
      end
    end
  end

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    bit   got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready[k] === 1'b1) got = 1;
    end
    req[k] = 1'b0;
    chk($sformatf("latency_dut%0d", k), n, lat);
    chk($sformatf("busy_at_ready_dut%0d", k), {31'd0, busy[k]}, 32'd1);
    @(posedge clk); #1;
    chk($sformatf("ready_one_cycle_dut%0d", k), {31'd0, ready[k]}, 32'd0);
    chk($sformatf("busy_after_dut%0d", k), {31'd0, busy[k]}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_state_dut%0d", k), {30'd0, st[k]}, 32'd0);
      chk($sformatf("rst_busy_dut%0d", k), {31'd0, busy[k]}, 32'd0);
      chk($sformatf("rst_ready_dut%0d", k), {31'd0, ready[k]}, 32'd0);
      chk($sformatf("rst_rdata_dut%0d", k), rdata[k], 32'd0);
      chk($sformatf("rst_err_dut%0d", k), {31'd0, err[k]}, 32'd0);
    end

    // Basic write then read, two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    // Misaligned read and write; misaligned write must not alias onto 0x10.
    txn(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 3);
    txn(0, 1'b1, 32'h13, 32'h55555555, 32'h0, 1'b1, 3);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    // Out-of-range write would alias to word 0 without the range check.
    txn(0, 1'b1, 32'h000, 32'hCAFEF00D, 32'h0, 1'b0, 3);
    txn(0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b1, 3);
    txn(0, 1'b0, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    txn(0, 1'b0, 32'h3FC, 32'h0, 32'hXXXXXXXX, 1'b0, 3);
    // Reset during WAIT discards the pending write and produces no strobe.
    txn(0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 3);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", {30'd0, st[0]}, 32'd0);
    chk("midrst_ready", {31'd0, ready[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (4) @(posedge clk);
    txn(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 3);

    // Zero wait states: alternating write/read, strobe every second cycle.
    for (int i = 0; i < 3; i++) begin
      txn(1, 1'b1, 32'h4 + 32'(4 * i), 32'hA0 + 32'(i), 32'h0, 1'b0, 1);
      txn(1, 1'b0, 32'h4 + 32'(4 * i), 32'h0, 32'hA0 + 32'(i), 1'b0, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained_dut0", q0.size(), 32'd0);
    chk("sb_drained_dut1", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
